// File: rtl/mist1032isa_fifo_wr_arbiter.sv
// rtl/mist1032isa_fifo_wr_arbiter.sv - packet-locked round-robin write arbiter in front of a sync FIFO
//
// Shares one FIFO write port between two requesters. A requester that wins
// a non-LAST beat keeps the port (LOCK0/LOCK1) until it sends LAST. When
// both requesters start a packet in IDLE, prio decides; prio then moves to
// the other requester.
//
// Ports:
//   iCLOCK, inRESET          clock, asynchronous active-low reset
//   iREMOVE                  synchronous flush of arbiter state and FIFO
//   iREQx_VALID/DATA/LAST    requester x beat (held stable while BUSY)
//   oREQx_BUSY               1 = beat not taken this cycle
//   oFIFO_WR_EN/WR_DATA      registered write beat toward the FIFO
//   oFIFO_REMOVE             flush forwarded to the FIFO
//   iFIFO_WR_FULL/COUNT      FIFO occupancy feedback
//   oGRANT                   one-hot lock owner, 00 when idle
module mist1032isa_fifo_wr_arbiter #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int D_N   = 2
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iREMOVE,
    input  logic           iREQ0_VALID,
    input  logic [N-1:0]   iREQ0_DATA,
    input  logic           iREQ0_LAST,
    output logic           oREQ0_BUSY,
    input  logic           iREQ1_VALID,
    input  logic [N-1:0]   iREQ1_DATA,
    input  logic           iREQ1_LAST,
    output logic           oREQ1_BUSY,
    output logic           oFIFO_WR_EN,
    output logic [N-1:0]   oFIFO_WR_DATA,
    output logic           oFIFO_REMOVE,
    input  logic           iFIFO_WR_FULL,
    input  logic [D_N-1:0] iFIFO_COUNT,
    output logic [1:0]     oGRANT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // COUNT wraps to 0 when the FIFO is full, so FULL supplies the top value.
    localparam logic [D_N:0]   OCC_FULL  = (D_N+1)'(DEPTH);
    localparam logic [D_N+1:0] OCC_LIMIT = (D_N+2)'(DEPTH - 1);

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           wr_en_q, wr_en_d;
    logic [N-1:0]   wr_data_q, wr_data_d;
    logic [1:0]     grant_q, grant_d;

    logic [D_N:0]   occ;
    logic [D_N+1:0] occ_pending;
    logic           space;
    logic           elig0, elig1;
    logic           acc0, acc1;

    always_comb begin
        occ         = iFIFO_WR_FULL ? OCC_FULL : {1'b0, iFIFO_COUNT};
        // The beat on oFIFO_WR_EN lands at the next edge, so count it as
        // already occupying a slot. Same-cycle reads are not credited.
        occ_pending = {1'b0, occ} + {{(D_N+1){1'b0}}, wr_en_q};
        space       = (occ_pending <= OCC_LIMIT);

        elig0 = (state_q == LOCK0) || ((state_q == IDLE) && (!iREQ1_VALID || !prio_q));
        elig1 = (state_q == LOCK1) || ((state_q == IDLE) && (!iREQ0_VALID ||  prio_q));

        // BUSY deliberately ignores the requester's own VALID.
        oREQ0_BUSY = !(elig0 && space && !iREMOVE);
        oREQ1_BUSY = !(elig1 && space && !iREMOVE);

        acc0 = iREQ0_VALID && !oREQ0_BUSY;
        acc1 = iREQ1_VALID && !oREQ1_BUSY;
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        if (iREMOVE) begin
            state_d = IDLE;
            prio_d  = 1'b0;
        end else if (acc0) begin
            wr_en_d   = 1'b1;
            wr_data_d = iREQ0_DATA;
            if (iREQ0_LAST) begin
                state_d = IDLE;
                prio_d  = 1'b1;
            end else begin
                state_d = LOCK0;
            end
        end else if (acc1) begin
            wr_en_d   = 1'b1;
            wr_data_d = iREQ1_DATA;
            if (iREQ1_LAST) begin
                state_d = IDLE;
                prio_d  = 1'b0;
            end else begin
                state_d = LOCK1;
            end
        end

        case (state_d)
            LOCK0:   grant_d = 2'b01;
            LOCK1:   grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            grant_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            grant_q   <= grant_d;
        end
    end

    assign oFIFO_WR_EN   = wr_en_q;
    assign oFIFO_WR_DATA = wr_data_q;
    assign oFIFO_REMOVE  = iREMOVE;
    assign oGRANT        = grant_q;

endmodule

// File: tb/tb_mist1032isa_fifo_wr_arbiter.sv
// tb/tb_mist1032isa_fifo_wr_arbiter.sv - scoreboard bench for mist1032isa_fifo_wr_arbiter
module tb_mist1032isa_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        inRESET = 1'b1;
    logic        iREMOVE = 1'b0;
    logic        iREQ0_VALID = 1'b0, iREQ0_LAST = 1'b0;
    logic [15:0] iREQ0_DATA = 16'h0;
    logic        iREQ1_VALID = 1'b0, iREQ1_LAST = 1'b0;
    logic [15:0] iREQ1_DATA = 16'h0;
    logic        oREQ0_BUSY, oREQ1_BUSY;
    logic        oFIFO_WR_EN, oFIFO_REMOVE;
    logic [15:0] oFIFO_WR_DATA;
    logic        iFIFO_WR_FULL;
    logic [1:0]  iFIFO_COUNT;
    logic [1:0]  oGRANT;

    int n_tests = 0;
    int n_fail  = 0;

    mist1032isa_fifo_wr_arbiter #(.N(16), .DEPTH(4), .D_N(2)) dut (
        .iCLOCK(clk), .inRESET(inRESET), .iREMOVE(iREMOVE),
        .iREQ0_VALID(iREQ0_VALID), .iREQ0_DATA(iREQ0_DATA), .iREQ0_LAST(iREQ0_LAST), .oREQ0_BUSY(oREQ0_BUSY),
        .iREQ1_VALID(iREQ1_VALID), .iREQ1_DATA(iREQ1_DATA), .iREQ1_LAST(iREQ1_LAST), .oREQ1_BUSY(oREQ1_BUSY),
        .oFIFO_WR_EN(oFIFO_WR_EN), .oFIFO_WR_DATA(oFIFO_WR_DATA), .oFIFO_REMOVE(oFIFO_REMOVE),
        .iFIFO_WR_FULL(iFIFO_WR_FULL), .iFIFO_COUNT(iFIFO_COUNT), .oGRANT(oGRANT)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Requester beat queues {last, data}, write-stream and FIFO read-back scoreboards.
    logic [16:0] q0[$], q1[$];
    logic [15:0] exp_q[$], rd_exp_q[$];
    logic        acc0 = 1'b0, acc1 = 1'b0, prev_acc = 1'b0, rm_seen = 1'b0;
    logic        mid0 = 1'b0, mid1 = 1'b0;
    int          wr_cnt = 0;

    // FIFO model (DEPTH 4): count is updated with <= so the DUT sees it after the edge.
    logic [15:0] fq[$];
    logic [2:0]  fcount = 3'd0;
    logic        rd = 1'b0;
    assign iFIFO_WR_FULL = (fcount == 3'd4);
    assign iFIFO_COUNT   = fcount[1:0];

    always @(posedge clk or negedge inRESET) begin
        logic [15:0] d;
        if (!inRESET) begin
            fq.delete();
            fcount <= 3'd0;
        end else if (oFIFO_REMOVE) begin
            fq.delete();
            fcount <= 3'd0;
        end else begin
            if (oFIFO_WR_EN) check("fifo_no_overflow", 32'(fq.size() < 4), 32'd1);
            if (rd && fq.size() != 0) begin
                d = fq.pop_front();
                if (rd_exp_q.size() == 0) check("fifo_read_unexpected", 32'(d), 32'hFFFF_FFFF);
                else check("fifo_read", 32'(d), 32'(rd_exp_q.pop_front()));
            end
            if (oFIFO_WR_EN && fq.size() < 4) fq.push_back(oFIFO_WR_DATA);
            fcount <= 3'(fq.size());
        end
    end

    // Monitor: compares each presented write beat and its one-cycle latency.
    always @(negedge clk) begin
        if (!inRESET) begin
            prev_acc = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
            rm_seen = 1'b0;
        end else begin
            if (prev_acc || oFIFO_WR_EN) check("wr_latency", 32'(oFIFO_WR_EN), 32'(prev_acc));
            if (oFIFO_WR_EN) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("wr_unexpected", 32'(oFIFO_WR_DATA), 32'hFFFF_FFFF);
                else check("wr_data", 32'(oFIFO_WR_DATA), 32'(exp_q.pop_front()));
            end
            acc0 = iREQ0_VALID && !oREQ0_BUSY;
            acc1 = iREQ1_VALID && !oREQ1_BUSY;
            if (acc0 && acc1) check("single_accept", 32'd2, 32'd1);
            prev_acc = acc0 || acc1;
            rm_seen  = iREMOVE;
        end
    end

    // Requester drivers: pop on accept, abandon a truncated packet on flush, drop all on reset.
    always @(posedge clk) begin
        logic [16:0] b;
        #1;
        if (!inRESET) begin
            q0.delete(); q1.delete();
            mid0 = 1'b0; mid1 = 1'b0;
        end else begin
            if (acc0) begin b = q0.pop_front(); mid0 = !b[16]; end
            if (acc1) begin b = q1.pop_front(); mid1 = !b[16]; end
            if (rm_seen) begin
                if (mid0) while (q0.size() != 0) begin b = q0.pop_front(); if (b[16]) break; end
                if (mid1) while (q1.size() != 0) begin b = q1.pop_front(); if (b[16]) break; end
                mid0 = 1'b0; mid1 = 1'b0;
            end
        end
        acc0 = 1'b0; acc1 = 1'b0; rm_seen = 1'b0;
        iREQ0_VALID = (q0.size() != 0);
        if (q0.size() != 0) begin b = q0[0]; iREQ0_LAST = b[16]; iREQ0_DATA = b[15:0]; end
        else begin iREQ0_LAST = 1'b0; iREQ0_DATA = 16'h0; end
        iREQ1_VALID = (q1.size() != 0);
        if (q1.size() != 0) begin b = q1[0]; iREQ1_LAST = b[16]; iREQ1_DATA = b[15:0]; end
        else begin iREQ1_LAST = 1'b0; iREQ1_DATA = 16'h0; end
    end

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || oFIFO_WR_EN) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check(name, 32'd1, 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((fcount != 0 || q0.size() != 0 || q1.size() != 0 || oFIFO_WR_EN) && n < 60) begin
            rd = (fcount != 0);
            @(posedge clk); #1;
            n++;
        end
        rd = 1'b0;
        if (n >= 60) check(name, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #1 inRESET = 1'b0;
        #1;
        check("rst_wr_en", 32'(oFIFO_WR_EN), 32'd0);
        check("rst_wr_data", 32'(oFIFO_WR_DATA), 32'd0);
        check("rst_grant", 32'(oGRANT), 32'd0);
        check("rst_remove", 32'(oFIFO_REMOVE), 32'd0);
        repeat (2) @(posedge clk);
        #1 inRESET = 1'b1;

        // Test 1: single beats from requester 0
        @(negedge clk);
        check("t1_idle_busy0", 32'(oREQ0_BUSY), 32'd0);
        check("t1_idle_busy1", 32'(oREQ1_BUSY), 32'd0);
        q0.push_back({1'b1, 16'h1111}); q0.push_back({1'b1, 16'h2222});
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
        rd_exp_q.push_back(16'h1111); rd_exp_q.push_back(16'h2222);
        @(negedge clk);
        check("t1_busy0", 32'(oREQ0_BUSY), 32'd0);
        check("t1_busy1_blocked", 32'(oREQ1_BUSY), 32'd1);
        check("t1_grant_a", 32'(oGRANT), 32'd0);
        @(negedge clk);
        check("t1_grant_b", 32'(oGRANT), 32'd0);
        check("t1_wr_en", 32'(oFIFO_WR_EN), 32'd1);
        wait_quiet("t1_timeout");
        drain("t1_drain_timeout");

        // Flush pulse with nothing pending resets prio to 0
        @(posedge clk); #1 iREMOVE = 1'b1;
        @(negedge clk);
        check("flush_forward", 32'(oFIFO_REMOVE), 32'd1);
        @(posedge clk); #1 iREMOVE = 1'b0;

        // Test 2: alternating single-beat packets
        @(negedge clk);
        q0.push_back({1'b1, 16'h00A0}); q0.push_back({1'b1, 16'h00A1});
        q1.push_back({1'b1, 16'h00B0}); q1.push_back({1'b1, 16'h00B1});
        foreach (exp_q[i]) ;
        exp_q.push_back(16'h00A0); exp_q.push_back(16'h00B0); exp_q.push_back(16'h00A1); exp_q.push_back(16'h00B1);
        rd_exp_q.push_back(16'h00A0); rd_exp_q.push_back(16'h00B0); rd_exp_q.push_back(16'h00A1); rd_exp_q.push_back(16'h00B1);
        @(negedge clk);
        check("t2_busy0", 32'(oREQ0_BUSY), 32'd0);
        check("t2_busy1", 32'(oREQ1_BUSY), 32'd1);
        wait_quiet("t2_timeout");
        drain("t2_drain_timeout");

        // Test 3: 3-beat packet locks out requester 1
        @(negedge clk);
        q0.push_back({1'b0, 16'h0010}); q0.push_back({1'b0, 16'h0011}); q0.push_back({1'b1, 16'h0012});
        q1.push_back({1'b1, 16'h0020});
        exp_q.push_back(16'h0010); exp_q.push_back(16'h0011); exp_q.push_back(16'h0012); exp_q.push_back(16'h0020);
        rd_exp_q.push_back(16'h0010); rd_exp_q.push_back(16'h0011); rd_exp_q.push_back(16'h0012); rd_exp_q.push_back(16'h0020);
        @(negedge clk);
        check("t3_busy0_n1", 32'(oREQ0_BUSY), 32'd0);
        check("t3_busy1_n1", 32'(oREQ1_BUSY), 32'd1);
        @(negedge clk);
        check("t3_grant_n2", 32'(oGRANT), 32'd1);
        check("t3_busy1_n2", 32'(oREQ1_BUSY), 32'd1);
        @(negedge clk);
        check("t3_grant_n3", 32'(oGRANT), 32'd1);
        check("t3_busy1_n3", 32'(oREQ1_BUSY), 32'd1);
        @(negedge clk);
        check("t3_grant_n4", 32'(oGRANT), 32'd0);
        check("t3_busy1_n4", 32'(oREQ1_BUSY), 32'd0);
        wait_quiet("t3_timeout");
        drain("t3_drain_timeout");

        // Test 4: stream 6 beats into a 4-deep FIFO with no reads
        @(negedge clk);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            q0.push_back({1'b1, 16'h0030 + 16'(i)});
            exp_q.push_back(16'h0030 + 16'(i));
            rd_exp_q.push_back(16'h0030 + 16'(i));
        end
        repeat (5) @(negedge clk);
        check("t4_busy_at_full", 32'(oREQ0_BUSY), 32'd1);
        repeat (4) @(negedge clk);
        check("t4_count_full", 32'(fcount), 32'd4);
        check("t4_writes", 32'(wr_cnt), 32'd4);
        check("t4_pending", 32'(q0.size()), 32'd2);
        check("t4_busy_hold", 32'(oREQ0_BUSY), 32'd1);
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
        @(negedge clk);
        check("t4_busy_after_read", 32'(oREQ0_BUSY), 32'd0);
        repeat (4) @(negedge clk);
        check("t4_writes_after_read", 32'(wr_cnt), 32'd5);
        check("t4_count_refull", 32'(fcount), 32'd4);
        check("t4_pending_after_read", 32'(q0.size()), 32'd1);
        check("t4_busy_refull", 32'(oREQ0_BUSY), 32'd1);
        drain("t4_drain_timeout");

        // Test 5: flush truncates a 4-beat packet after beat 2
        @(negedge clk);
        q0.push_back({1'b0, 16'h0040}); q0.push_back({1'b0, 16'h0041});
        q0.push_back({1'b0, 16'h0042}); q0.push_back({1'b1, 16'h0043});
        exp_q.push_back(16'h0040); exp_q.push_back(16'h0041);
        @(negedge clk);
        check("t5_busy0_n1", 32'(oREQ0_BUSY), 32'd0);
        q1.push_back({1'b1, 16'h0050});
        exp_q.push_back(16'h0050);
        rd_exp_q.push_back(16'h0050);
        @(posedge clk); #1;
        @(posedge clk); #1 iREMOVE = 1'b1;
        @(negedge clk);
        check("t5_busy0_flush", 32'(oREQ0_BUSY), 32'd1);
        check("t5_busy1_flush", 32'(oREQ1_BUSY), 32'd1);
        check("t5_remove_fwd", 32'(oFIFO_REMOVE), 32'd1);
        check("t5_inflight", 32'(oFIFO_WR_EN), 32'd1);
        @(posedge clk); #1 iREMOVE = 1'b0;
        @(negedge clk);
        check("t5_grant_idle", 32'(oGRANT), 32'd0);
        check("t5_fifo_empty", 32'(fcount), 32'd0);
        check("t5_wr_en_off", 32'(oFIFO_WR_EN), 32'd0);
        check("t5_busy1_granted", 32'(oREQ1_BUSY), 32'd0);
        wait_quiet("t5_timeout");
        drain("t5_drain_timeout");

        // Test 6: asynchronous reset in the middle of a requester-1 packet
        @(negedge clk);
        q1.push_back({1'b0, 16'h0060}); q1.push_back({1'b0, 16'h0061}); q1.push_back({1'b1, 16'h0062});
        exp_q.push_back(16'h0060);
        @(negedge clk);
        check("t6_busy1_n1", 32'(oREQ1_BUSY), 32'd0);
        @(negedge clk);
        check("t6_grant_lock1", 32'(oGRANT), 32'd2);
        @(posedge clk); #3 inRESET = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(oFIFO_WR_EN), 32'd0);
        check("t6_rst_wr_data", 32'(oFIFO_WR_DATA), 32'd0);
        check("t6_rst_grant", 32'(oGRANT), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 inRESET = 1'b1;
        @(negedge clk);
        check("t6_post_busy0", 32'(oREQ0_BUSY), 32'd0);
        check("t6_post_busy1", 32'(oREQ1_BUSY), 32'd0);
        check("t6_post_fifo", 32'(fcount), 32'd0);
        q0.push_back({1'b1, 16'h0071});
        q1.push_back({1'b1, 16'h0070});
        exp_q.push_back(16'h0071); exp_q.push_back(16'h0070);
        rd_exp_q.push_back(16'h0071); rd_exp_q.push_back(16'h0070);
        @(negedge clk);
        check("t6_prio0_busy0", 32'(oREQ0_BUSY), 32'd0);
        check("t6_prio0_busy1", 32'(oREQ1_BUSY), 32'd1);
        wait_quiet("t6_timeout");
        drain("t6_drain_timeout");

        check("wr_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("rd_scoreboard_empty", 32'(rd_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mist1032isa_fifo_wr_arbiter.md
# mist1032isa_fifo_wr_arbiter

Two-requester write arbiter in front of one `mist1032isa_sync_fifo` instance. It shares the FIFO write port between two producers using packet-locked round-robin. It registers the write beat toward the FIFO and blocks any write that could overflow it, including a beat still in flight. It also forwards the queue flush.

## Interface
- N, 16, data width; equals the FIFO N
- DEPTH, 4, FIFO depth; must equal 2^D_N
- D_N, 2, log2(DEPTH); equals the FIFO D_N
- iCLOCK  in  1  clock
- inRESET  in  1  reset inRESET, asynchronous, active-low; clock iCLOCK
- iREMOVE  in  1  synchronous flush of arbiter and FIFO
- iREQ0_VALID  in  1  requester 0 beat valid
- iREQ0_DATA  in  N  requester 0 beat data
- iREQ0_LAST  in  1  beat is last of packet
- oREQ0_BUSY  out  1  1 = beat not accepted this cycle; hold it
- iREQ1_VALID, iREQ1_DATA, iREQ1_LAST, oREQ1_BUSY  same as requester 0
- oFIFO_WR_EN  out  1  to FIFO iWR_EN
- oFIFO_WR_DATA  out  N  to FIFO iWR_DATA
- oFIFO_REMOVE  out  1  to FIFO iREMOVE
- iFIFO_WR_FULL  in  1  from FIFO oWR_FULL
- iFIFO_COUNT  in  D_N  from FIFO oCOUNT
- oGRANT  out  2  one-hot current owner; 00 = idle/no lock

## Operation
- Occupancy `occ` is D_N+1 bits: `occ` = DEPTH if iFIFO_WR_FULL, else {0, iFIFO_COUNT}.
- Space: `space` = (occ + b_wr_en) <= DEPTH-1. Evaluate at D_N+2 bits so the sum cannot wrap.
  - Reads in the same cycle are ignored (conservative).
- State machine with states IDLE, LOCK0 and LOCK1. Round-robin pointer `prio` (0 or 1) gives the winner in IDLE when both requesters are valid.
- Grant:
  - Requester 0 is eligible when state=LOCK0, or when state=IDLE and (!iREQ1_VALID or prio=0).
  - Requester 1 is eligible by the mirror rule.
  - oREQx_BUSY = !(eligible_x && space && !iREMOVE). It does not depend on requester x's own VALID.
- Accept: a beat is accepted when iREQx_VALID && !oREQx_BUSY. At most one beat is accepted per cycle.
- Transitions on an accepted beat:
  - LAST=0: go to LOCKx.
  - LAST=1: go to IDLE and set prio = other requester.
  - No accepted beat: state and prio hold.
  - In LOCKx the other requester stays busy regardless of its VALID.
- Output regs:
  - b_wr_en <= accept.
  - b_wr_data <= accepted data when accept; otherwise hold the previous value.
- oGRANT = 01 in LOCK0, 10 in LOCK1, 00 in IDLE.
- Flush: oFIFO_REMOVE = iREMOVE (combinational). While iREMOVE=1:
  - no beat is accepted;
  - next state is IDLE, prio <= 0, b_wr_en <= 0.
  - A beat presented on oFIFO_WR_EN in the iREMOVE cycle is discarded by the FIFO, because FIFO remove has priority.
  - A packet in progress is truncated; requesters restart at packet boundaries.
- Constraint: requesters keep VALID, DATA and LAST stable while BUSY=1.

## Timing
- Reset values: state IDLE, prio 0, oFIFO_WR_EN 0, oFIFO_WR_DATA 0, oGRANT 00.
  - oFIFO_REMOVE follows iREMOVE.
  - Right after reset, BUSY = 0 for requester 0 (eligible, since prio=0) and for requester 1 only when iREQ0_VALID=0.
- Latency: a beat accepted at edge k appears on oFIFO_WR_EN/DATA during cycle k+1 and is written into the FIFO at edge k+1.
- Throughput: 1 beat/cycle while space holds. At occ = DEPTH-1 with a beat in flight, BUSY=1 for one cycle.
- Reset asserted mid-packet: immediate return to IDLE, and any in-flight beat is lost.
- Simultaneous first requests in IDLE: winner = prio. The other requester waits at least until the winner's packet ends.

## Test plan
- Single beats, requester 0 only (LAST=1, data 0x1111, 0x2222): oFIFO_WR_EN high one cycle after each accept; data in order; oGRANT stays 00.
- Both requesters valid continuously with single-beat packets: accepts alternate 0,1,0,1; the FIFO reads back 0xA0,0xB0,0xA1,0xB1.
- Requester 0 sends 3-beat packet (0x10,0x11,0x12 LAST) while requester 1 is valid: oGRANT=01 for beats 2–3; oREQ1_BUSY=1 until the 0x12 accept; requester 1 is accepted next cycle.
- Requester 0 streams 6 beats into a DEPTH=4 FIFO with no reads: exactly 4 writes; BUSY high from the cycle occ+pending reaches 4; FIFO never overflows.
  - One FIFO read then yields exactly one more accept.
- iREMOVE pulse mid-packet (after beat 2 of 4): no accept that cycle; state IDLE, oGRANT 00, FIFO empty next cycle; requester 1 then granted immediately.
- inRESET low mid-stream: all outputs return to reset values asynchronously; after release, requester 0 is eligible and prio=0.
